// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: widths, ALU op codes, ID/EX payload struct and helpers.
package mips_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned ALU_OP_W  = 4;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    // ALU operation encodings
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_LUI = 4'd10;

    // Contents of the EX stage register (PC field is kept separately, it is optional)
    typedef struct packed {
        logic                  valid;
        logic [DATA_W-1:0]     operand_a;
        logic [DATA_W-1:0]     operand_b;
        logic [DATA_W-1:0]     rt_data;
        logic [REG_IDX_W-1:0]  rs;
        logic [REG_IDX_W-1:0]  rt;
        logic [REG_IDX_W-1:0]  write_reg;
        logic [REG_IDX_W-1:0]  shamt;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic [ALU_OP_W-1:0]   alu_op;
    } ex_payload_t;

    // ALU B-operand select: immediate for I-type, rt data otherwise
    function automatic logic [DATA_W-1:0] sel_operand_b(
        input logic              alu_src,
        input logic [DATA_W-1:0] imm_ext,
        input logic [DATA_W-1:0] rt_data
    );
        return alu_src ? imm_ext : rt_data;
    endfunction

    // Destination select: rd for R-type, rt for I-type
    function automatic logic [REG_IDX_W-1:0] sel_write_reg(
        input logic                 reg_dst,
        input logic [REG_IDX_W-1:0] rd,
        input logic [REG_IDX_W-1:0] rt
    );
        return reg_dst ? rd : rt;
    endfunction

endpackage

// File: rtl/mips_load_use_detect.sv
// Load-use hazard detection: a load in EX whose destination is a source of the instruction in ID.
module mips_load_use_detect
    import mips_pkg::*;
(
    input  logic                 ex_valid_i,
    input  logic                 ex_mem_read_i,
    input  logic [REG_IDX_W-1:0] ex_write_reg_i,
    input  logic                 id_valid_i,
    input  logic [REG_IDX_W-1:0] id_rs_i,
    input  logic [REG_IDX_W-1:0] id_rt_i,
    input  logic                 id_uses_rt_i,
    output logic                 load_use_o
);

    logic load_in_ex;
    logic rs_match;
    logic rt_match;

    // Hazard equation; a load to $0 never creates a dependency
    always_comb begin
        load_in_ex = ex_valid_i & ex_mem_read_i & (ex_write_reg_i != REG_ZERO);
        rs_match   = (ex_write_reg_i == id_rs_i);
        rt_match   = id_uses_rt_i & (ex_write_reg_i == id_rt_i);
        load_use_o = load_in_ex & id_valid_i & (rs_match | rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand-B/destination muxing, load-use detection,
// stall hold and flush/bubble insertion. Optional PC field enabled by ID_EX_PC_EN.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [DATA_W-1:0]    id_rs_data,
    input  logic [DATA_W-1:0]    id_rt_data,
    input  logic [DATA_W-1:0]    id_imm_ext,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [REG_IDX_W-1:0] id_shamt,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 id_mem_write,
    input  logic                 id_mem_to_reg,
    input  logic                 id_alu_src,
    input  logic                 id_reg_dst,
    input  logic [ALU_OP_W-1:0]  id_alu_op,
    input  logic                 id_uses_rt,
`ifdef ID_EX_PC_EN
    input  logic [DATA_W-1:0]    id_pc_plus4,
    output logic [DATA_W-1:0]    ex_pc_plus4,
`endif
    output logic                 ex_valid,
    output logic [DATA_W-1:0]    ex_operand_a,
    output logic [DATA_W-1:0]    ex_operand_b,
    output logic [DATA_W-1:0]    ex_rt_data,
    output logic [REG_IDX_W-1:0] ex_rs,
    output logic [REG_IDX_W-1:0] ex_rt,
    output logic [REG_IDX_W-1:0] ex_write_reg,
    output logic [REG_IDX_W-1:0] ex_shamt,
    output logic                 ex_reg_write,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_mem_to_reg,
    output logic [ALU_OP_W-1:0]  ex_alu_op,
    output logic                 load_use
);

    ex_payload_t ex_q;
    ex_payload_t ex_d;
    ex_payload_t id_capture;
    logic        load_bubble;
    logic        hold;

    // Hazard check against the instruction currently in EX
    mips_load_use_detect u_load_use_detect (
        .ex_valid_i     (ex_q.valid),
        .ex_mem_read_i  (ex_q.mem_read),
        .ex_write_reg_i (ex_q.write_reg),
        .id_valid_i     (id_valid),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_uses_rt_i   (id_uses_rt),
        .load_use_o     (load_use)
    );

    // Decoded ID instruction as it would appear in EX; enables gated by id_valid
    always_comb begin
        id_capture            = '0;
        id_capture.valid      = id_valid;
        id_capture.operand_a  = id_rs_data;
        id_capture.operand_b  = sel_operand_b(id_alu_src, id_imm_ext, id_rt_data);
        id_capture.rt_data    = id_rt_data;
        id_capture.rs         = id_rs;
        id_capture.rt         = id_rt;
        id_capture.write_reg  = sel_write_reg(id_reg_dst, id_rd, id_rt);
        id_capture.shamt      = id_shamt;
        id_capture.reg_write  = id_reg_write  & id_valid;
        id_capture.mem_read   = id_mem_read   & id_valid;
        id_capture.mem_write  = id_mem_write  & id_valid;
        id_capture.mem_to_reg = id_mem_to_reg & id_valid;
        id_capture.alu_op     = id_alu_op;
    end

    // Update priority: flush > stall > load-use bubble > normal load
    always_comb begin
        load_bubble = 1'b0;
        hold        = 1'b0;
        ex_d        = ex_q;
        if (flush) begin
            load_bubble = 1'b1;
        end else if (stall) begin
            hold = 1'b1;
        end else if (load_use) begin
            load_bubble = 1'b1;
        end
        if (load_bubble) begin
            ex_d = '0;
        end else if (!hold) begin
            ex_d = id_capture;
        end
    end

    // EX stage register
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

`ifdef ID_EX_PC_EN
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_d;

    // PC follows the same hold/bubble rules as the payload
    always_comb begin
        pc_d = pc_q;
        if (load_bubble) begin
            pc_d = '0;
        end else if (!hold) begin
            pc_d = id_pc_plus4;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign ex_pc_plus4 = pc_q;
`endif

    assign ex_valid      = ex_q.valid;
    assign ex_operand_a  = ex_q.operand_a;
    assign ex_operand_b  = ex_q.operand_b;
    assign ex_rt_data    = ex_q.rt_data;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_write_reg  = ex_q.write_reg;
    assign ex_shamt      = ex_q.shamt;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_alu_op     = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage (also builds with ID_EX_PC_EN defined).
module tb_id_ex_stage;
    import mips_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rtd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [4:0]  shamt;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic [3:0]  op;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm_ext, id_pc_plus4;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
    logic [3:0]  id_alu_op;
    logic        id_uses_rt;
    logic        ex_valid;
    logic [31:0] ex_operand_a, ex_operand_b, ex_rt_data;
    logic [4:0]  ex_rs, ex_rt, ex_write_reg, ex_shamt;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [3:0]  ex_alu_op;
    logic        load_use;
`ifdef ID_EX_PC_EN
    logic [31:0] ex_pc_plus4;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];
    exp_t model = '0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_alu_op(id_alu_op), .id_uses_rt(id_uses_rt),
`ifdef ID_EX_PC_EN
        .id_pc_plus4(id_pc_plus4), .ex_pc_plus4(ex_pc_plus4),
`endif
        .ex_valid(ex_valid), .ex_operand_a(ex_operand_a), .ex_operand_b(ex_operand_b),
        .ex_rt_data(ex_rt_data), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg),
        .ex_shamt(ex_shamt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op),
        .load_use(load_use)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic rw,
                         input logic mr, input logic mw, input logic m2r, input logic src,
                         input logic dst, input logic [3:0] op, input logic urt,
                         input logic [31:0] pc);
        id_valid = v; id_rs_data = rsd; id_rt_data = rtd; id_imm_ext = imm;
        id_rs = rs; id_rt = rt; id_rd = rd; id_shamt = sh;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
        id_alu_src = src; id_reg_dst = dst; id_alu_op = op; id_uses_rt = urt;
        id_pc_plus4 = pc;
    endtask

    // Reference behaviour of one clock edge (reset handled by caller)
    function automatic exp_t model_next(input exp_t cur, input logic st, input logic fl,
                                        input logic lu);
        exp_t n;
        n = '0;
        if (fl) begin
            n = '0;
        end else if (st) begin
            n = cur;
        end else if (lu) begin
            n = '0;
        end else begin
            n.valid = id_valid;
            n.a     = id_rs_data;
            n.b     = id_alu_src ? id_imm_ext : id_rt_data;
            n.rtd   = id_rt_data;
            n.rs    = id_rs;
            n.rt    = id_rt;
            n.wr    = id_reg_dst ? id_rd : id_rt;
            n.shamt = id_shamt;
            n.rw    = id_reg_write  & id_valid;
            n.mr    = id_mem_read   & id_valid;
            n.mw    = id_mem_write  & id_valid;
            n.m2r   = id_mem_to_reg & id_valid;
            n.op    = id_alu_op;
`ifdef ID_EX_PC_EN
            n.pc    = id_pc_plus4;
`endif
        end
        return n;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o = '0;
        o.valid = ex_valid; o.a = ex_operand_a; o.b = ex_operand_b; o.rtd = ex_rt_data;
        o.rs = ex_rs; o.rt = ex_rt; o.wr = ex_write_reg; o.shamt = ex_shamt;
        o.rw = ex_reg_write; o.mr = ex_mem_read; o.mw = ex_mem_write; o.m2r = ex_mem_to_reg;
        o.op = ex_alu_op;
`ifdef ID_EX_PC_EN
        o.pc = ex_pc_plus4;
`endif
        return o;
    endfunction

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_ex(input string tag);
        exp_t e;
        exp_t o;
        vectors++;
        o = observed();
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s/ex scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s/ex observed=%h expected=%h", tag, o, e);
            end
        end
    endtask

    // One clock: check load_use before the edge, then the registered EX contents after it
    task automatic step(input string tag, input logic rst, input logic st, input logic fl,
                        input logic exp_lu);
        exp_t nxt;
        reset = rst; stall = st; flush = fl;
        #1;
        if (!rst) check_word({tag, "/load_use"}, 32'(load_use), 32'(exp_lu));
        nxt = rst ? exp_t'('0) : model_next(model, st, fl, exp_lu);
        sb_q.push_back(nxt);
        model = nxt;
        @(posedge clk);
        #1;
        compare_ex(tag);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        @(negedge clk);

        // Reset with every ID input at all-ones
        drive(1'b1, '1, '1, '1, 5'd31, 5'd31, 5'd31, 5'd31, 1, 1, 1, 1, 1, 1, 4'hF, 1, '1);
        step("reset", 1, 0, 0, 0);
        reset = 1'b0;
        #1;
        check_word("reset_load_use", 32'(load_use), 32'd0);
        #1;

        // addi: immediate selected for operand B
        drive(1, 32'h11, 32'd5, 32'hFFFF_FFF6, 5'd1, 5'd2, 5'd0, 5'd0, 1, 0, 0, 0, 1, 0, ALU_ADD, 0, 32'h0040_0000);
        step("addi", 0, 0, 0, 0);
        check_word("addi_opb", ex_operand_b, 32'hFFFF_FFF6);

        // R-type: rd selected as destination
        drive(1, 32'h100, 32'h200, 32'h0000_4820, 5'd3, 5'd4, 5'd9, 5'd2, 1, 0, 0, 0, 0, 1, ALU_SLL, 1, 32'h0040_0004);
        step("rtype", 0, 0, 0, 0);
        check_word("rtype_wr", 32'(ex_write_reg), 32'd9);

        // lw $8 then dependent add on rs -> bubble, then replay
        drive(1, 32'h1000, 32'hDEAD, 32'h10, 5'd29, 5'd8, 5'd0, 5'd0, 1, 1, 0, 1, 1, 0, ALU_ADD, 0, 32'h0040_0008);
        step("lw8", 0, 0, 0, 0);
        drive(1, 32'hAAAA, 32'hBBBB, 32'h0, 5'd8, 5'd5, 5'd10, 5'd0, 1, 0, 0, 0, 0, 1, ALU_ADD, 1, 32'h0040_000C);
        step("dep_rs_bubble", 0, 0, 0, 1);
        check_word("bubble_mem_read", 32'(ex_mem_read), 32'd0);
        step("dep_rs_replay", 0, 0, 0, 0);

        // Load to $0 never hazards
        drive(1, 32'h2000, 32'h0, 32'h4, 5'd29, 5'd0, 5'd0, 5'd0, 1, 1, 0, 1, 1, 0, ALU_ADD, 0, 32'h0040_0010);
        step("lw0", 0, 0, 0, 0);
        drive(1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd11, 5'd0, 1, 0, 0, 0, 0, 1, ALU_OR, 1, 32'h0040_0014);
        step("use_r0", 0, 0, 0, 0);

        // Store with rt dependency hazards; addi with rt as destination does not
        drive(1, 32'h1000, 32'hDEAD, 32'h10, 5'd29, 5'd8, 5'd0, 5'd0, 1, 1, 0, 1, 1, 0, ALU_ADD, 0, 32'h0040_0018);
        step("lw8_b", 0, 0, 0, 0);
        drive(1, 32'h3000, 32'h77, 32'h8, 5'd29, 5'd8, 5'd0, 5'd0, 0, 0, 1, 0, 1, 0, ALU_ADD, 1, 32'h0040_001C);
        step("sw_rt_hazard", 0, 0, 0, 1);
        drive(1, 32'h1000, 32'hDEAD, 32'h10, 5'd29, 5'd8, 5'd0, 5'd0, 1, 1, 0, 1, 1, 0, ALU_ADD, 0, 32'h0040_0020);
        step("lw8_c", 0, 0, 0, 0);
        drive(1, 32'h5, 32'h6, 32'h7, 5'd3, 5'd8, 5'd0, 5'd0, 1, 0, 0, 0, 1, 0, ALU_ADD, 0, 32'h0040_0024);
        step("addi_rt_no_hazard", 0, 0, 0, 0);

        // Invalid ID slot: enables forced low
        drive(0, 32'h55, 32'h66, 32'h77, 5'd8, 5'd8, 5'd8, 5'd1, 1, 1, 1, 1, 0, 1, ALU_SUB, 1, 32'h0040_0028);
        step("invalid_id", 0, 0, 0, 0);

        // Stall for three cycles with changing ID inputs, hazard present
        drive(1, 32'h1000, 32'hDEAD, 32'h10, 5'd29, 5'd8, 5'd0, 5'd0, 1, 1, 0, 1, 1, 0, ALU_ADD, 0, 32'h0040_002C);
        step("lw8_d", 0, 0, 0, 0);
        drive(1, 32'hAAAA, 32'hBBBB, 32'h0, 5'd8, 5'd5, 5'd10, 5'd0, 1, 0, 0, 0, 0, 1, ALU_ADD, 1, 32'h0040_0030);
        step("stall1", 0, 1, 0, 1);
        drive(1, 32'hCCCC, 32'hDDDD, 32'h1, 5'd8, 5'd6, 5'd12, 5'd3, 1, 0, 0, 0, 0, 1, ALU_AND, 1, 32'h0040_0034);
        step("stall2", 0, 1, 0, 1);
        drive(1, 32'hEEEE, 32'hFFFF, 32'h2, 5'd9, 5'd1, 5'd13, 5'd4, 1, 0, 0, 0, 0, 1, ALU_OR, 0, 32'h0040_0038);
        step("stall3", 0, 1, 0, 0);
        check_word("stall_hold_opa", ex_operand_a, 32'h1000);
        check_word("stall_hold_mr", 32'(ex_mem_read), 32'd1);

        // Stall and flush together: flush wins
        drive(1, 32'hAAAA, 32'hBBBB, 32'h0, 5'd8, 5'd5, 5'd10, 5'd0, 1, 0, 0, 0, 0, 1, ALU_ADD, 1, 32'h0040_003C);
        step("stall_flush", 0, 1, 1, 1);
        check_word("stall_flush_valid", 32'(ex_valid), 32'd0);

        // Reset during a stall clears the stage
        drive(1, 32'h100, 32'h200, 32'h0, 5'd3, 5'd4, 5'd9, 5'd2, 1, 0, 0, 0, 0, 1, ALU_SUB, 1, 32'h0040_0040);
        step("pre_reset", 0, 0, 0, 0);
        step("reset_mid_stall", 1, 1, 0, 0);

        // PC field: carried for one cycle, zeroed by flush
        drive(1, 32'h9, 32'h3, 32'h4, 5'd1, 5'd2, 5'd0, 5'd0, 1, 0, 0, 0, 1, 0, ALU_ADD, 0, 32'h0040_0004);
        step("pc_load", 0, 0, 0, 0);
`ifdef ID_EX_PC_EN
        check_word("pc_value", ex_pc_plus4, 32'h0040_0004);
`endif
        step("pc_flush", 0, 0, 1, 0);
`ifdef ID_EX_PC_EN
        check_word("pc_flushed", ex_pc_plus4, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
